// File: rtl/rc4_keystream_engine.sv
// RC4 keystream engine: owns the S-box and key store, runs identity fill and
// key scheduling after start, then produces one keystream word per accepted
// handshake.
//
// state | meaning
// IDLE  | waiting for the first start after reset; key writes accepted
// INIT  | identity fill, S[i] <= i, one entry per cycle
// KSA   | key scheduling, one swap per cycle
// GEN   | keystream generation over valid/ready; key writes staged for next start
module rc4_keystream_engine #(
    parameter int WIDTH   = 4,
    parameter int KEY_LEN = 8,
    parameter int KA_W    = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_we,
    input  logic [KA_W-1:0]  key_addr,
    input  logic [WIDTH-1:0] key_data,
    input  logic             start,
    output logic             busy,
    output logic             ready_ks,
    output logic             ks_valid,
    input  logic             ks_ready,
    output logic [WIDTH-1:0] ks_data
);
    localparam int DEPTH = 1 << WIDTH;
    localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(DEPTH - 1);
    localparam logic [KA_W-1:0]  LAST_KEY = KA_W'(KEY_LEN - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_KSA, ST_GEN} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] s_box [DEPTH];
    logic [WIDTH-1:0] key   [KEY_LEN];
    logic [WIDTH-1:0] i_idx;
    logic [WIDTH-1:0] j_idx;
    logic [KA_W-1:0]  k_idx;
    logic             last_i;
    logic             key_wr_ok;
    logic             gen_step;
    logic [WIDTH-1:0] ksa_jn;
    logic [WIDTH-1:0] gen_in;
    logic [WIDTH-1:0] gen_jn;
    logic [WIDTH-1:0] s_in;
    logic [WIDTH-1:0] s_jn;
    logic [WIDTH-1:0] gen_t;
    logic [WIDTH-1:0] gen_word;

    assign last_i = (i_idx == LAST_IDX);

    // k_idx tracks i mod KEY_LEN so no divider is needed for odd key lengths
    assign ksa_jn = j_idx + s_box[i_idx] + key[k_idx];

    assign gen_in = i_idx + WIDTH'(1);
    assign s_in   = s_box[gen_in];
    assign gen_jn = j_idx + s_in;
    assign s_jn   = s_box[gen_jn];
    assign gen_t  = s_in + s_jn;

    // a start in GEN abandons the stream, so no step is taken alongside it
    assign gen_step  = (state == ST_GEN) && !start && (!ks_valid || ks_ready);
    assign key_wr_ok = key_we && ((state == ST_IDLE) || (state == ST_GEN))
                       && (int'(key_addr) < KEY_LEN);

    // output lookup sees the post-swap array without waiting for the swap to land
    always_comb begin
        if (gen_t == gen_in) begin
            gen_word = s_jn;
        end else if (gen_t == gen_jn) begin
            gen_word = s_in;
        end else begin
            gen_word = s_box[gen_t];
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state decode; start is deliberately ignored while scheduling
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start)  state_nxt = ST_INIT;
            ST_INIT: if (last_i) state_nxt = ST_KSA;
            ST_KSA:  if (last_i) state_nxt = ST_GEN;
            ST_GEN:  if (start)  state_nxt = ST_INIT;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // status outputs are pure state decode
    always_comb begin
        busy     = (state == ST_INIT) || (state == ST_KSA);
        ready_ks = (state == ST_GEN);
    end

    // index counters; i wraps to 0 naturally at the end of INIT and KSA
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_idx <= '0;
            j_idx <= '0;
            k_idx <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        i_idx <= '0;
                        j_idx <= '0;
                        k_idx <= '0;
                    end
                end
                ST_INIT: begin
                    i_idx <= i_idx + WIDTH'(1);
                    j_idx <= '0;
                    k_idx <= '0;
                end
                ST_KSA: begin
                    i_idx <= i_idx + WIDTH'(1);
                    j_idx <= last_i ? '0 : ksa_jn;
                    k_idx <= (k_idx == LAST_KEY) ? '0 : k_idx + KA_W'(1);
                end
                ST_GEN: begin
                    if (start) begin
                        i_idx <= '0;
                        j_idx <= '0;
                    end else if (gen_step) begin
                        i_idx <= gen_in;
                        j_idx <= gen_jn;
                    end
                end
                default: begin
                    i_idx <= '0;
                    j_idx <= '0;
                    k_idx <= '0;
                end
            endcase
        end
    end

    // S-box storage; no reset since contents are rebuilt by INIT on every start
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            s_box[i_idx] <= i_idx;
        end else if (state == ST_KSA) begin
            // when i == jn both writes carry the same value, so the entry survives
            s_box[i_idx]  <= s_box[ksa_jn];
            s_box[ksa_jn] <= s_box[i_idx];
        end else if (gen_step) begin
            s_box[gen_in] <= s_jn;
            s_box[gen_jn] <= s_in;
        end
    end

    // key store; writes during scheduling or out of range are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < KEY_LEN; n++) begin
                key[n] <= '0;
            end
        end else if (key_wr_ok) begin
            key[key_addr] <= key_data;
        end
    end

    // keystream output register; data holds while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ks_valid <= 1'b0;
            ks_data  <= '0;
        end else if (gen_step) begin
            ks_valid <= 1'b1;
            ks_data  <= gen_word;
        end else if ((state != ST_GEN) || start) begin
            ks_valid <= 1'b0;
        end
    end

endmodule
